// File: rtl/reflet_ram_16_pkg.sv
// reflet_ram_16_pkg: constants shared between the RAM and the reflet CPU
package reflet_ram_16_pkg;
    localparam int WORD_WIDTH = 16;
endpackage

// File: rtl/reflet_ram_core.sv
// reflet_ram_core: plain word array with synchronous write and read-first registered read
module reflet_ram_core
    import reflet_ram_16_pkg::*;
#(
    parameter int addrSize = 8
) (
    input  logic                  clk,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [addrSize-1:0]   addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);
    logic [WORD_WIDTH-1:0] mem [2**addrSize] = '{default: '0};
    logic [WORD_WIDTH-1:0] q = '0;
    assign rdata = q;
    // write the addressed word; the read samples the old word in the same edge
    always_ff @(posedge clk) begin
        if (wr) mem[addr] <= wdata;
        if (rd) q <= mem[addr];
    end
endmodule

// File: rtl/reflet_ram_16.sv
// reflet_ram_16: selectable 16-bit RAM whose output is zero when not addressed
module reflet_ram_16
    import reflet_ram_16_pkg::*;
#(
    parameter int addrSize = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [addrSize-1:0]   addr,
    input  logic [WORD_WIDTH-1:0] data_in,
    input  logic                  write_en,
    output logic [WORD_WIDTH-1:0] data_out
);
    logic                  sel;
    logic [WORD_WIDTH-1:0] rdata;
    reflet_ram_core #(.addrSize(addrSize)) core (
        .clk(clk),
        .wr(enable & write_en & ~reset),
        .rd(enable & ~reset),
        .addr(addr),
        .wdata(data_in),
        .rdata(rdata)
    );
    // remember whether the last edge was a selected access; cleared at once by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sel <= 1'b0;
        else sel <= enable;
    end
    assign data_out = sel ? rdata : '0;
endmodule

// File: tb/tb_reflet_ram_16.sv
// tb_reflet_ram_16: directed checks of reset, read latency, read-first and deselect zeroing
module tb_reflet_ram_16;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] data_in = '0;
    logic        write_en = 1'b0;
    logic [15:0] data_out;
    int          errors = 0;
    int          checks = 0;

    reflet_ram_16 #(.addrSize(8)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .addr(addr),
        .data_in(data_in),
        .write_en(write_en),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic we, input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        enable = en;
        write_en = we;
        addr = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        enable = 1'b1;
        write_en = 1'b1;
        addr = 8'h05;
        data_in = 16'hBEEF;
        @(posedge clk); #1;
        check("reset_out0", data_out, 16'h0000);
        @(posedge clk); #1;
        check("reset_out1", data_out, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b0;
        write_en = 1'b0;
        cyc(1, 1, 8'h10, 16'h1234);
        check("wr_old_0x10", data_out, 16'h0000);
        cyc(1, 0, 8'h10, 16'h0000);
        check("rd_0x10", data_out, 16'h1234);
        cyc(1, 0, 8'h05, 16'h0000);
        check("reset_write_blocked", data_out, 16'h0000);
        cyc(1, 1, 8'h20, 16'hAAAA);
        cyc(1, 1, 8'h20, 16'h5555);
        check("read_first_old", data_out, 16'hAAAA);
        cyc(1, 0, 8'h20, 16'h0000);
        check("read_first_new", data_out, 16'h5555);
        cyc(1, 1, 8'hFF, 16'hFFFF);
        cyc(1, 1, 8'h00, 16'h0001);
        check("wr_old_0x00", data_out, 16'h0000);
        cyc(1, 0, 8'hFF, 16'h0000);
        check("rd_top", data_out, 16'hFFFF);
        cyc(1, 0, 8'h00, 16'h0000);
        check("rd_bottom", data_out, 16'h0001);
        cyc(1, 1, 8'h03, 16'h00C3);
        cyc(1, 0, 8'h03, 16'h0000);
        check("rd_0x03", data_out, 16'h00C3);
        cyc(0, 1, 8'h03, 16'hDEAD);
        check("deselect_zero", data_out, 16'h0000);
        cyc(0, 0, 8'hxx, 16'h0000);
        check("deselect_x_addr", data_out, 16'h0000);
        cyc(1, 0, 8'h03, 16'h0000);
        check("no_write_deselected", data_out, 16'h00C3);
        cyc(1, 1, 8'h40, 16'h7E7E);
        cyc(1, 0, 8'h40, 16'h0000);
        check("rd_0x40", data_out, 16'h7E7E);
        #2 reset = 1'b1;
        #1 check("async_reset_out", data_out, 16'h0000);
        @(posedge clk); #1;
        check("reset_hold_out", data_out, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 0, 8'h40, 16'h0000);
        check("survive_reset_0x40", data_out, 16'h7E7E);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reflet_ram_16.md
Name: reflet_ram_16

Overview:
- Single-port synchronous RAM with 16-bit words and a registered read path, used as data/stack memory beside the reflet CPU.
- Mapped in the upper half of the CPU address space; the system decoder drives `enable` from CPU addr[15] and passes the low address bits.
- Output is forced to zero when not selected, so the system can OR it with other memory outputs (e.g. boot ROM) on a shared CPU data-in bus.

Parameters:
- addrSize, 8: number of address bits; depth = 2**addrSize words of 16 bits (the system instance uses 15).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  chip select; high = this RAM is addressed this cycle.
- addr  input  addrSize  word index into the array.
- data_in  input  16  write data.
- write_en  input  1  write strobe; effective only with enable high.
- data_out  output  16  registered read data; 0 when not selected or in reset.

Behaviour:
- Storage: array mem[0 .. 2**addrSize-1] of 16-bit words. All words are 0 at time zero for deterministic simulation. reset does not clear the array; contents survive reset.
- Reset: while reset is high, data_out is 0 immediately (asynchronous, no clock needed). No writes occur while reset is high. After reset deasserts, the first rising edge behaves normally.
- Write: at a rising edge with reset=0, enable=1 and write_en=1, mem[addr] <= data_in. Every other combination leaves the array unchanged.
- Read: at each rising edge with reset=0, the data_out register is loaded as follows:
  - enable=1: data_out <= mem[addr], with 1-cycle read latency.
  - enable=0: data_out <= 0.
- write_en does not suppress the read. A cycle with enable=1 and write_en=1 also updates data_out.
- Read-during-write to the same address is read-first: data_out shows the old word. The new word is visible from a read in the next cycle.
- Addressing:
  - addr is always in range because depth is exactly 2**addrSize.
  - No wrap logic is needed; the top index 2**addrSize-1 is fully usable.
  - X/Z on addr while enable=0 must not disturb data_out (it stays 0).
- data_out is 0 in every cycle following a deselected cycle. This is what makes OR-combining with the ROM bus legal.
- No handshake: single-cycle accesses with fixed latency, and back-to-back accesses on every clock.

Decomposition:
- Shared package: constant WORD_WIDTH = 16, shared with reflet_cpu (wordsize 16). No typedefs required.
- One natural sub-module, reflet_ram_core:
  - Plain array with synchronous write and read-first registered read.
  - The top level adds the enable gating, zero-forcing and async reset of the output register.
- Otherwise implement flat.

Test Plan:
- Assert reset=1 with enable=1, addr=0x0005, clk toggling -> data_out stays 0x0000; a write of 0xBEEF attempted during reset is not stored (later read of 0x0005 returns 0x0000).
- Release reset; write 0x1234 to addr 0x0010 (enable=1, write_en=1), next cycle read 0x0010 -> data_out=0x1234 exactly one clock after the read address is presented.
- Write 0xAAAA to 0x0020, then same-cycle write 0x5555 to 0x0020 while reading it -> data_out=0xAAAA that cycle, 0x5555 on the following read.
- Write 0xFFFF to addr 2**addrSize-1 and 0x0001 to addr 0 -> reads return 0xFFFF and 0x0001; no aliasing between the ends.
- Store 0x00C3 at 0x0003, read it, then drop enable for one cycle -> data_out returns to 0x0000 the next edge; write_en=1 with enable=0 leaves mem[0x0003]=0x00C3.
- Write 0x7E7E to 0x0040, pulse reset high mid-operation between edges -> data_out goes 0 asynchronously; after release a read of 0x0040 returns 0x7E7E.
